// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM port between instruction fetch and data access.
// Grants are combinational, contention is round-robin; read data returns one cycle after the grant.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 30,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  i_flush,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   output logic                  ram_re,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  busy
);

   typedef enum logic {WIN_I = 1'b0, WIN_D = 1'b1} winner_e;

   winner_e last_q, last_d;
   logic    pend_i_q, pend_i_d;
   logic    pend_d_q, pend_d_d;
   logic    busy_q, busy_d;

   // Under contention the requester that did not win last time goes first.
   assign i_gnt = ~reset & i_req & (~d_req | (last_q == WIN_D));
   assign d_gnt = ~reset & d_req & (~i_req | (last_q == WIN_I));

   always_comb begin
      ram_addr = '0;
      ram_din  = '0;
      ram_re   = 1'b0;
      ram_we   = 1'b0;
      if (i_gnt) begin
         ram_addr = i_addr;
         ram_re   = 1'b1;
      end else if (d_gnt) begin
         ram_addr = d_addr;
         ram_re   = ~d_we;
         ram_we   = d_we;
         ram_din  = d_we ? d_wdata : '0;
      end
   end

   always_comb begin
      pend_i_d = i_gnt;
      pend_d_d = d_gnt & ~d_we;
      busy_d   = pend_i_d | pend_d_d;
      last_d   = last_q;
      if (i_gnt)      last_d = WIN_I;
      else if (d_gnt) last_d = WIN_D;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_i_q <= 1'b0;
         pend_d_q <= 1'b0;
         busy_q   <= 1'b0;
         last_q   <= WIN_D;
      end else begin
         pend_i_q <= pend_i_d;
         pend_d_q <= pend_d_d;
         busy_q   <= busy_d;
         last_q   <= last_d;
      end
   end

   // A flush drops the fetch granted last cycle; reset drops any read granted before it.
   assign i_rvalid = pend_i_q & ~i_flush & ~reset;
   assign d_rvalid = pend_d_q & ~reset;
   assign i_rdata  = i_rvalid ? ram_dout : '0;
   assign d_rdata  = d_rvalid ? ram_dout : '0;
   assign busy     = busy_q & ~reset;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of mem_arbiter against a small synchronous RAM model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, i_flush, d_req, d_we;
   logic [29:0] i_addr, d_addr;
   logic [31:0] d_wdata;
   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, ram_re, ram_we, busy;
   logic [31:0] i_rdata, d_rdata, ram_din;
   logic [29:0] ram_addr;
   logic [31:0] ram_dout = '0;
   logic [31:0] mem [256];

   int checks = 0;
   int errors = 0;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_flush(i_flush),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_re(ram_re), .ram_we(ram_we),
      .ram_dout(ram_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_din;
      if (ram_re) ram_dout <= mem[ram_addr[7:0]];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [29:0] ia, input logic fl,
                        input logic dr, input logic we, input logic [29:0] da,
                        input logic [31:0] wd);
      i_req = ir; i_addr = ia; i_flush = fl;
      d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
   endtask

   // Advance to the middle of the current cycle (outputs settled), then to just after the next edge.
   task automatic mid();
      @(negedge clk);
   endtask

   task automatic next();
      @(posedge clk); #1;
   endtask

   initial begin
      for (int k = 0; k < 256; k++) mem[k] = 32'h0;
      mem[8'h10] = 32'hDEADBEEF;
      mem[8'h20] = 32'hCAFE0020;

      // Reset with both requests high: nothing may be granted.
      reset = 1'b1;
      drive(1, 30'h10, 0, 1, 0, 30'h20, 32'h0);
      next(); mid();
      chk("rst_i_gnt", i_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_ram_re", ram_re, 0);
      chk("rst_busy", busy, 0);
      next();

      // First cycle after reset, idle.
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      mid();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_i_rvalid", i_rvalid, 0);
      chk("post_rst_d_rvalid", d_rvalid, 0);
      next();

      // Contention: I, D, I, D.
      drive(1, 30'h10, 0, 1, 0, 30'h20, 32'h0);
      mid();
      chk("c1_i_gnt", i_gnt, 1);
      chk("c1_d_gnt", d_gnt, 0);
      chk("c1_ram_addr", ram_addr, 30'h10);
      next(); mid();
      chk("c2_i_gnt", i_gnt, 0);
      chk("c2_d_gnt", d_gnt, 1);
      chk("c2_ram_addr", ram_addr, 30'h20);
      chk("c2_i_rvalid", i_rvalid, 1);
      chk("c2_i_rdata", i_rdata, 32'hDEADBEEF);
      next(); mid();
      chk("c3_i_gnt", i_gnt, 1);
      chk("c3_d_gnt", d_gnt, 0);
      chk("c3_d_rvalid", d_rvalid, 1);
      chk("c3_d_rdata", d_rdata, 32'hCAFE0020);
      chk("c3_i_rvalid", i_rvalid, 0);
      next(); mid();
      chk("c4_i_gnt", i_gnt, 0);
      chk("c4_d_gnt", d_gnt, 1);
      chk("c4_busy", busy, 1);
      next();
      drive(0, 0, 0, 0, 0, 0, 0);
      mid();
      chk("c5_d_rvalid", d_rvalid, 1);
      chk("c5_i_gnt", i_gnt, 0);
      next();

      // Single fetch of 0x10.
      drive(1, 30'h10, 0, 0, 0, 0, 0);
      mid();
      chk("sf_i_gnt", i_gnt, 1);
      chk("sf_ram_re", ram_re, 1);
      chk("sf_ram_we", ram_we, 0);
      chk("sf_ram_addr", ram_addr, 30'h10);
      next();

      // Fetch data returns while a D write to 3 issues.
      drive(0, 0, 0, 1, 1, 30'h3, 32'h55);
      mid();
      chk("sf_i_rvalid", i_rvalid, 1);
      chk("sf_i_rdata", i_rdata, 32'hDEADBEEF);
      chk("wr_d_gnt", d_gnt, 1);
      chk("wr_ram_we", ram_we, 1);
      chk("wr_ram_re", ram_re, 0);
      chk("wr_ram_din", ram_din, 32'h55);
      chk("wr_ram_addr", ram_addr, 30'h3);
      next();

      // D read of 3 right after the write.
      drive(0, 0, 0, 1, 0, 30'h3, 32'h0);
      mid();
      chk("rd_d_gnt", d_gnt, 1);
      chk("rd_ram_re", ram_re, 1);
      chk("rd_ram_we", ram_we, 0);
      chk("wr_no_rvalid", d_rvalid, 0);
      next();
      drive(0, 0, 0, 0, 0, 0, 0);
      mid();
      chk("rd_d_rvalid", d_rvalid, 1);
      chk("rd_d_rdata", d_rdata, 32'h55);
      chk("rd_i_rvalid", i_rvalid, 0);
      next();

      // Flush: fetch at N, flush plus new fetch of 0x20 at N+1.
      drive(1, 30'h10, 0, 0, 0, 0, 0);
      mid();
      chk("fl_n_i_gnt", i_gnt, 1);
      next();
      drive(1, 30'h20, 1, 0, 0, 0, 0);
      mid();
      chk("fl_n1_i_gnt", i_gnt, 1);
      chk("fl_n1_i_rvalid", i_rvalid, 0);
      chk("fl_n1_i_rdata", i_rdata, 0);
      next();
      drive(0, 0, 0, 0, 0, 0, 0);
      mid();
      chk("fl_n2_i_rvalid", i_rvalid, 1);
      chk("fl_n2_i_rdata", i_rdata, 32'hCAFE0020);
      next();

      // Flush leaves a pending D read alone.
      drive(0, 0, 0, 1, 0, 30'h10, 0);
      next();
      drive(0, 0, 1, 0, 0, 0, 0);
      mid();
      chk("fl_d_rvalid", d_rvalid, 1);
      chk("fl_d_rdata", d_rdata, 32'hDEADBEEF);
      next();

      // Reset in the cycle after a D read grant.
      drive(0, 0, 0, 1, 0, 30'h20, 0);
      mid();
      chk("rr_d_gnt", d_gnt, 1);
      next();
      drive(0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      mid();
      chk("rr_n1_d_rvalid", d_rvalid, 0);
      chk("rr_n1_busy", busy, 0);
      chk("rr_n1_d_rdata", d_rdata, 0);
      next();
      reset = 1'b0;
      mid();
      chk("rr_n2_d_rvalid", d_rvalid, 0);
      chk("rr_n2_busy", busy, 0);
      next();

      // Idle for 10 cycles.
      for (int n = 0; n < 10; n++) begin
         mid();
         chk("idle_ram_re", ram_re, 0);
         chk("idle_ram_we", ram_we, 0);
         chk("idle_ram_addr", ram_addr, 0);
         chk("idle_busy", busy, 0);
         chk("idle_i_rdata", i_rdata, 0);
         chk("idle_d_rdata", d_rdata, 0);
         next();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 30, meaning the RAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the RAM word width.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk in 1 system clock; reset in 1 synchronous active-high reset.
REQ-004 SHALL have i_req in 1 for the instruction-fetch read request, and i_addr in ADDR_WIDTH for the fetch word address.
REQ-005 SHALL have i_gnt out 1, asserted when the fetch request is accepted this cycle.
REQ-006 SHALL have i_rvalid out 1 (fetch data valid) and i_rdata out DATA_WIDTH (fetch data).
REQ-007 SHALL have i_flush in 1, which discards any in-flight fetch response.
REQ-008 SHALL have d_req in 1 (data request), d_we in 1 (1 = write, 0 = read), d_addr in ADDR_WIDTH (data word address) and d_wdata in DATA_WIDTH (write data).
REQ-009 SHALL have d_gnt out 1, asserted when the data request is accepted this cycle.
REQ-010 SHALL have d_rvalid out 1 (load data valid) and d_rdata out DATA_WIDTH (load data).
REQ-011 SHALL have ram_addr out ADDR_WIDTH, ram_din out DATA_WIDTH, ram_re out 1 and ram_we out 1 (RAM port drive), and ram_dout in DATA_WIDTH (RAM read data, valid the cycle after the read edge).
REQ-012 SHALL have busy out 1, high while a read response is pending.

Function
REQ-013 SHALL share the single synchronous RAM port between fetch (I) and data (D); at most one access is issued per cycle.
REQ-014 SHALL make the grants combinational: when only one of i_req/d_req is high, that requester is granted in the same cycle.
REQ-015 SHALL resolve contention (both requests high) round-robin: grant the requester not granted most recently, then update the last_winner register on every grant.
REQ-016 SHALL never assert i_gnt and d_gnt in the same cycle, and never assert any grant while reset is high.
REQ-017 SHALL, for the granted requester only: ram_addr = granted address; ram_re = 1 for an I grant or a D read; ram_we = d_we for a D grant; ram_din = d_wdata for a D write.
REQ-018 SHALL hold ram_re, ram_we, ram_addr and ram_din at 0 in any cycle without a grant.
REQ-019 SHALL set pending-read flags pend_i/pend_d at the grant edge; the matching rvalid is high exactly one cycle after the read grant and is low otherwise.
REQ-020 SHALL drive i_rdata/d_rdata = ram_dout while the matching rvalid is high, and 0 otherwise.
REQ-021 SHALL produce no rvalid for a write; the grant is its completion.
REQ-022 SHALL be fully pipelined: a new grant may issue in the same cycle as an rvalid, giving throughput of one access per cycle.
REQ-023 SHALL, when i_flush is high, clear pend_i so that a fetch granted in an earlier cycle produces no i_rvalid.
REQ-024 SHALL NOT cancel a fetch granted in the same cycle as i_flush; that fetch returns i_rvalid normally.
REQ-025 SHALL leave d_rvalid unaffected by i_flush.
REQ-026 SHALL generate busy = pend_i | pend_d, registered.
REQ-027 SHALL guarantee i_rvalid and d_rvalid are never both high.
REQ-028 SHALL require requesters to hold req and payload stable until granted; behaviour with payload changing while ungranted is unspecified.

Reset
REQ-029 SHALL, on reset high at a clock edge, clear pend_i, pend_d and busy, and set last_winner = D, so that fetch wins the first contention after reset.
REQ-030 SHALL have all outputs 0 during reset and in the first cycle after reset.
REQ-031 SHALL suppress the rvalid of a read granted in the cycle before reset asserts.

Verification
REQ-032 SHALL cover single fetch: i_req=1, i_addr=0x10, RAM word 0x10 = 0xDEADBEEF -> i_gnt=1 and ram_re=1, ram_addr=0x10 same cycle; next cycle i_rvalid=1, i_rdata=0xDEADBEEF.
REQ-033 SHALL cover contention: both requests held high for 4 cycles after reset -> grants alternate I, D, I, D; no cycle has both grants.
REQ-034 SHALL cover back-to-back traffic: D write 0x55 to addr 3, then D read addr 3 the next cycle -> ram_we=1 then ram_re=1; d_rvalid=1 with d_rdata=0x55 one cycle after the read grant.
REQ-035 SHALL cover flush: fetch granted at cycle N, i_flush=1 at N+1 together with a new fetch to addr 0x20 -> no i_rvalid at N+1; i_rvalid=1 at N+2 with word 0x20.
REQ-036 SHALL cover reset mid-read: D read granted at cycle N, reset=1 at N+1 -> d_rvalid=0 and busy=0 at N+1 and N+2.
REQ-037 SHALL cover idle: no requests for 10 cycles -> ram_re=ram_we=0, busy=0, all rdata=0.
